// File: rtl/wcslscan.sv
`default_nettype none
// ============================================================================
// Module   : wcslscan
// Brief    : Debounced, interrupt-capable scanner for four Spacewar control boxes
// Revision : 1.0
// ============================================================================
module wcslscan #(
    parameter int SCAN_DIV = 64,
    parameter int DEB_N    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_poweron,
    input  logic        iobus_iob_reset,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_fm_datai,
    input  logic        iobus_iob_fm_status,
    input  logic        iobus_rdi_pulse,
    input  logic [3:9]  iobus_ios,
    input  logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi_req,
    output logic [0:35] iobus_iob_out,
    output logic        iobus_dr_split,
    output logic        iobus_rdi_data,
    input  logic [0:17] ctl1,
    input  logic [0:17] ctl2,
    input  logic [0:17] ctl3,
    input  logic [0:17] ctl4
);
    localparam logic [3:9]        c_dev_code = 7'b100_010_1;
    localparam int                c_tw       = $clog2(SCAN_DIV);
    localparam logic [c_tw-1:0]   c_reload   = c_tw'(SCAN_DIV - 1);
    localparam logic [3:0]        c_deb      = 4'(DEB_N);

    logic [2:0]      r_pia;
    logic            r_en;
    logic            r_chg;
    logic [c_tw-1:0] r_timer;
    logic [1:0]      r_bi;
    logic [0:17]     r_prev [4];
    logic [3:0]      r_cnt  [4];
    logic [0:17]     r_snap [4];

    logic        w_sel, w_cono_clr, w_cono_set, w_datai, w_coni;
    logic        w_tick, w_match, w_upd, w_chg_clr;
    logic [3:0]  w_cnt_nxt;
    logic [0:17] w_raw;
    logic [0:35] w_word;
    logic [0:35] w_out;
    logic [2:0]  w_pia_nxt;
    logic        w_unused;

    // Box lines are active high; the bus word reports them active low.
    function automatic logic [0:8] pack_box(input logic [0:17] c);
        return ~{c[12], c[13], c[10] | c[11], c[15], c[14], 4'b0000};
    endfunction

    assign w_sel      = (iobus_ios == c_dev_code);
    assign w_cono_clr = w_sel & iobus_cono_clear;
    assign w_cono_set = w_sel & iobus_cono_set;
    assign w_datai    = w_sel & iobus_iob_fm_datai;
    assign w_coni     = w_sel & iobus_iob_fm_status;

    always_comb begin
        w_raw = ctl1;
        case (r_bi)
            2'd0:    w_raw = ctl1;
            2'd1:    w_raw = ctl2;
            2'd2:    w_raw = ctl3;
            default: w_raw = ctl4;
        endcase
    end

    assign w_tick    = r_en && (r_timer == '0);
    assign w_match   = (w_raw == r_prev[r_bi]);
    assign w_cnt_nxt = !w_match                ? 4'd0 :
                       (r_cnt[r_bi] < c_deb)   ? r_cnt[r_bi] + 4'd1 : r_cnt[r_bi];
    // A DATAI read in progress defers the update; saturated cnt retries next visit.
    assign w_upd     = w_tick && (w_cnt_nxt == c_deb) && (w_raw != r_snap[r_bi]) && !w_datai;
    assign w_chg_clr = w_datai | (w_cono_set & iobus_iob_in[32]);
    assign w_pia_nxt = (w_cono_clr ? 3'b000 : r_pia) | (w_cono_set ? iobus_iob_in[33:35] : 3'b000);

    assign w_word = {pack_box(r_snap[3]), pack_box(r_snap[2]),
                     pack_box(r_snap[1]), pack_box(r_snap[0])};

    always_comb begin
        w_out = '0;
        if (w_datai) w_out = w_out | w_word;
        if (w_coni)  w_out[30:35] = w_out[30:35] | {1'b0, r_en, r_chg, r_pia};
    end

    assign iobus_iob_out  = w_out;
    assign iobus_dr_split = 1'b0;
    assign iobus_rdi_data = 1'b0;

    genvar k;
    generate
        for (k = 1; k <= 7; k++) begin : g_pi_req
            assign iobus_pi_req[k] = r_chg && (r_pia == 3'(k));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || iobus_iob_reset) begin
            r_pia   <= 3'b000;
            r_en    <= 1'b0;
            r_chg   <= 1'b0;
            r_timer <= c_reload;
            r_bi    <= 2'd0;
            for (int b = 0; b < 4; b++) begin
                r_prev[b] <= '0;
                r_cnt[b]  <= 4'd0;
                r_snap[b] <= '0;
            end
        end else begin
            if (!r_en) begin
                r_timer <= c_reload;
            end else if (w_tick) begin
                r_timer <= c_reload;
                r_bi    <= r_bi + 2'd1;
            end else begin
                r_timer <= r_timer - c_tw'(1);
            end

            if (w_tick) begin
                if (!w_match) r_prev[r_bi] <= w_raw;
                r_cnt[r_bi] <= w_cnt_nxt;
                if (w_upd) r_snap[r_bi] <= w_raw;
            end

            if (w_upd)          r_chg <= 1'b1;
            else if (w_chg_clr) r_chg <= 1'b0;

            r_pia <= w_pia_nxt;
            if (w_cono_clr) r_en <= 1'b0;
            if (w_cono_set && iobus_iob_in[31]) r_en <= 1'b1;
        end
    end

    assign w_unused = &{1'b0, iobus_iob_poweron, iobus_datao_clear, iobus_datao_set,
                        iobus_rdi_pulse, iobus_iob_in[0:30]};

endmodule
`default_nettype wire

// File: tb/tb_wcslscan.sv
`default_nettype none
// ============================================================================
// Module   : tb_wcslscan
// Brief    : Self-checking bench for wcslscan against a behavioural scanner model
// Revision : 1.0
// ============================================================================
module tb_wcslscan;
    localparam int         SCAN_DIV = 4;
    localparam int         DEB_N    = 2;
    localparam logic [3:9] DEV      = 7'b100_010_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set;
    logic        iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status;
    logic        iobus_rdi_pulse;
    logic [3:9]  iobus_ios;
    logic [0:35] iobus_iob_in;
    logic [1:7]  iobus_pi_req;
    logic [0:35] iobus_iob_out;
    logic        iobus_dr_split, iobus_rdi_data;
    logic [0:17] ctl1, ctl2, ctl3, ctl4;

    always #5 clk = ~clk;

    wcslscan #(.SCAN_DIV(SCAN_DIV), .DEB_N(DEB_N)) dut (
        .clk(clk), .reset(reset),
        .iobus_iob_poweron(iobus_iob_poweron), .iobus_iob_reset(iobus_iob_reset),
        .iobus_datao_clear(iobus_datao_clear), .iobus_datao_set(iobus_datao_set),
        .iobus_cono_clear(iobus_cono_clear), .iobus_cono_set(iobus_cono_set),
        .iobus_iob_fm_datai(iobus_iob_fm_datai), .iobus_iob_fm_status(iobus_iob_fm_status),
        .iobus_rdi_pulse(iobus_rdi_pulse), .iobus_ios(iobus_ios), .iobus_iob_in(iobus_iob_in),
        .iobus_pi_req(iobus_pi_req), .iobus_iob_out(iobus_iob_out),
        .iobus_dr_split(iobus_dr_split), .iobus_rdi_data(iobus_rdi_data),
        .ctl1(ctl1), .ctl2(ctl2), .ctl3(ctl3), .ctl4(ctl4)
    );

    // Reference model: run length of identical samples per box, tick phase in enabled cycles.
    int          m_pia, m_phase, m_ticks;
    bit          m_en, m_chg;
    logic [0:17] m_last [4];
    int          m_run  [4];
    logic [0:17] m_snap [4];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [0:17] raw_box(input int b);
        case (b)
            0:       return ctl1;
            1:       return ctl2;
            2:       return ctl3;
            default: return ctl4;
        endcase
    endfunction

    function automatic logic [0:8] box_field(input logic [0:17] c);
        logic [0:8] f = '1;
        if (c[12])          f[0] = 1'b0;
        if (c[13])          f[1] = 1'b0;
        if (c[10] || c[11]) f[2] = 1'b0;
        if (c[15])          f[3] = 1'b0;
        if (c[14])          f[4] = 1'b0;
        return f;
    endfunction

    function automatic logic [0:35] exp_out();
        logic [0:35] w = '0;
        bit sel = (iobus_ios == DEV);
        if (sel && iobus_iob_fm_datai)
            for (int b = 0; b < 4; b++) w[27 - 9*b +: 9] = box_field(m_snap[b]);
        if (sel && iobus_iob_fm_status) begin
            w[31]    = w[31] | m_en;
            w[32]    = w[32] | m_chg;
            w[33:35] = w[33:35] | 3'(m_pia);
        end
        return w;
    endfunction

    function automatic logic [1:7] exp_pi();
        logic [1:7] r = '0;
        for (int k = 1; k <= 7; k++) if (m_chg && m_pia == k) r[k] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit          sel, datai, set_chg;
        int          b;
        logic [0:17] r;
        sel   = (iobus_ios == DEV);
        datai = sel && iobus_iob_fm_datai;
        if (reset || iobus_iob_reset) begin
            m_pia = 0; m_en = 0; m_chg = 0; m_phase = 0; m_ticks = 0;
            for (int i = 0; i < 4; i++) begin
                m_last[i] = '0; m_run[i] = 1; m_snap[i] = '0;
            end
        end else begin
            set_chg = 0;
            if (m_en) begin
                if (m_phase == SCAN_DIV - 1) begin
                    b = m_ticks % 4;
                    r = raw_box(b);
                    if (r == m_last[b]) m_run[b] = (m_run[b] < 1000) ? m_run[b] + 1 : 1000;
                    else begin m_last[b] = r; m_run[b] = 1; end
                    if (m_run[b] > DEB_N && r != m_snap[b] && !datai) begin
                        m_snap[b] = r;
                        set_chg   = 1;
                    end
                    m_ticks++;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end else begin
                m_phase = 0;
            end
            if (set_chg) m_chg = 1;
            else if (datai || (sel && iobus_cono_set && iobus_iob_in[32])) m_chg = 0;
            if (sel && iobus_cono_clear) begin m_pia = 0; m_en = 0; end
            if (sel && iobus_cono_set) begin
                m_pia = m_pia | int'(iobus_iob_in[33:35]);
                m_en  = m_en | iobus_iob_in[31];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_eq("iob_out", 64'(iobus_iob_out), 64'(exp_out()));
            check_eq("pi_req", 64'(iobus_pi_req), 64'(exp_pi()));
            check_eq("tieoffs", 64'({iobus_dr_split, iobus_rdi_data}), 64'(0));
        end
    endtask

    task automatic read_datai(input string tag, input logic [0:35] exp);
        iobus_ios = DEV; iobus_iob_fm_datai = 1'b1; #1;
        check_eq(tag, 64'(iobus_iob_out), 64'(exp));
        step(1);
        iobus_iob_fm_datai = 1'b0;
    endtask

    task automatic read_coni(input string tag, input logic [0:35] exp);
        iobus_ios = DEV; iobus_iob_fm_status = 1'b1; #1;
        check_eq(tag, 64'(iobus_iob_out), 64'(exp));
        step(1);
        iobus_iob_fm_status = 1'b0;
    endtask

    task automatic cono_set(input logic [0:35] val);
        iobus_ios = DEV; iobus_iob_in = val; iobus_cono_set = 1'b1;
        step(1);
        iobus_cono_set = 1'b0; iobus_iob_in = '0;
    endtask

    initial begin
        reset = 1'b1;
        iobus_iob_poweron = 0; iobus_iob_reset = 0; iobus_datao_clear = 0; iobus_datao_set = 0;
        iobus_cono_clear = 0; iobus_cono_set = 0; iobus_iob_fm_datai = 0; iobus_iob_fm_status = 0;
        iobus_rdi_pulse = 0; iobus_ios = DEV; iobus_iob_in = '0;
        ctl1 = '0; ctl2 = '0; ctl3 = '0; ctl4 = '0;
        step(2);
        reset = 1'b0;

        check_eq("rst_pi", 64'(iobus_pi_req), 64'(0));
        read_datai("rst_datai", 36'o777777777777);
        read_coni("rst_coni", 36'o0);

        // Enable on PI channel 5 and debounce a held fire button on box 1.
        cono_set(36'o25);
        read_coni("coni_25", 36'o25);
        ctl1[12] = 1'b1;
        step(64);
        check_eq("t2_pi", 64'(iobus_pi_req), 64'(7'b0000100));
        read_coni("t2_coni", 36'o35);
        read_datai("t2_datai", 36'o777777777377);

        // A short glitch on box 2 never reaches the snapshot.
        ctl2[14] = 1'b1;
        step(3);
        ctl2[14] = 1'b0;
        step(64);
        check_eq("t3_pi", 64'(iobus_pi_req), 64'(0));
        read_datai("t3_datai", 36'o777777777377);

        // A held DATAI defers the box 4 update until it is released.
        ctl4[15] = 1'b1;
        iobus_iob_fm_datai = 1'b1;
        step(80);
        check_eq("t4_held_word", 64'(iobus_iob_out), 64'(36'o777777777377));
        check_eq("t4_held_pi", 64'(iobus_pi_req), 64'(0));
        iobus_iob_fm_datai = 1'b0;
        step(20);
        check_eq("t4_pi", 64'(iobus_pi_req), 64'(7'b0000100));

        cono_set(36'o10);
        check_eq("t5_pi", 64'(iobus_pi_req), 64'(0));
        read_coni("t5_coni", 36'o25);
        read_datai("t4_datai", 36'o737777777377);
        iobus_cono_clear = 1'b1;
        step(1);
        iobus_cono_clear = 1'b0;
        read_coni("t5_coni_clr", 36'o0);
        ctl1 = '0; ctl4 = '0;
        step(100);
        read_datai("t5_frozen", 36'o737777777377);
        check_eq("t5_pi_off", 64'(iobus_pi_req), 64'(0));

        // Bus reset mid-debounce on box 3 must restart the sample count.
        ctl3[14] = 1'b1;
        cono_set(36'o25);
        step(40);
        iobus_iob_reset = 1'b1;
        step(1);
        iobus_iob_reset = 1'b0;
        cono_set(36'o25);
        step(36);
        read_datai("t6_partial", 36'o777777777777);
        step(16);
        check_eq("t6_pi", 64'(iobus_pi_req), 64'(7'b0000100));
        read_datai("t6_done", 36'o777757777777);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 119) == 0) ctl1 = 18'($urandom);
            if ($urandom_range(0, 119) == 0) ctl2 = 18'($urandom);
            if ($urandom_range(0, 119) == 0) ctl3 = 18'($urandom);
            if ($urandom_range(0, 119) == 0) ctl4 = 18'($urandom);
            iobus_ios           = ($urandom_range(0, 7) == 0) ? 7'($urandom) : DEV;
            iobus_iob_in        = {4'($urandom), 32'($urandom)};
            iobus_cono_set      = ($urandom_range(0, 29) == 0);
            iobus_cono_clear    = ($urandom_range(0, 99) == 0);
            iobus_iob_fm_datai  = ($urandom_range(0, 9) == 0);
            iobus_iob_fm_status = ($urandom_range(0, 4) == 0);
            iobus_datao_set     = 1'($urandom);
            iobus_datao_clear   = 1'($urandom);
            iobus_rdi_pulse     = 1'($urandom);
            iobus_iob_poweron   = 1'($urandom);
            iobus_iob_reset     = ($urandom_range(0, 999) == 0);
            reset               = ($urandom_range(0, 1499) == 0);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wcslscan.md
# wcslscan

Debounced, interrupt-capable scanner for the four Spacewar control boxes. It sits on the IO bus at device code 424. It samples the boxes round-robin on a programmable tick, debounces each box, and holds a stable snapshot for DATAI. It raises a PI request when the snapshot changes, with the PI channel and scan enable set by CONO.

## Interface
- SCAN_DIV, 64: clock cycles per scan tick, ≥2.
- DEB_N, 3: consecutive equal samples after a change before the box snapshot updates, 1..15.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set, iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status, iobus_rdi_pulse  in  1 each  IO bus controls
- iobus_ios  in  [3:9]  device select; this device = 7'b100_010_1
- iobus_iob_in  in  [0:35]  bus data in
- iobus_pi_req  out  [1:7]  PI request, one-hot
- iobus_iob_out  out  [0:35]  bus data out
- iobus_dr_split, iobus_rdi_data  out  1  tied 0
- ctl1..ctl4  in  [0:17] each  raw box lines, asynchronous to software, treated as clk-synchronous levels

## Operation
- Registers:
  - pia[33:35]
  - en
  - chg
  - tick timer
  - box index bi (0..3 ↔ ctl1..ctl4)
  - per box: prev[18], cnt[4], snap[18]
- Packing per box p = {c[12], c[13], c[10]|c[11], c[15], c[14], 0, 000}, taken from snap.
- Word W = ~{p4, p3, p2, p1}: p1 occupies bits 27–35, p4 bits 0–8.
- All bus actions are gated by select (ios match):
  - CONO clear: pia←0, en←0.
  - CONO set: pia |= iob_in[33:35]; en |= iob_in[31]; if iob_in[32], chg←0.
  - CONI (iob_fm_status): out[30:35] = {0, en, chg, pia}; all else 0.
  - DATAI (iob_fm_datai): out = W. chg←0 every cycle it is asserted.
  - Out is 0 when not selected.
  - DATAO is ignored.
- Scanning:
  - When en=0, the timer holds at SCAN_DIV-1 and bi holds.
  - When en=1, the timer decrements each cycle. At 0 it generates a tick, reloads, and bi advances mod 4 after the tick.
- On a tick, sample box bi (raw r):
  - If r≠prev: prev←r, cnt←0.
  - Else if cnt<DEB_N: cnt←cnt+1.
  - Update condition: the post-update cnt reaches DEB_N, r≠snap, and DATAI is not asserted. When it holds, snap←r and chg←1.
  - If DATAI is asserted, the update is deferred. cnt saturates at DEB_N, so the next tick on that box re-evaluates the update.
- If a chg-set and a chg-clear fall in the same cycle, set wins.
- iobus_pi_req[k] = chg & (pia==k), for k=1..7. pia=0 requests nothing.
- reset or iob_reset clears every register: pia, en, chg, timer←SCAN_DIV-1, bi←0, prev/cnt/snap←0.
- iob_poweron is unused beyond its effect through iob_reset.

## Timing
- Reset values:
  - pi_req = 0.
  - iob_out = 0; a selected DATAI reads 777777777777₈ and a selected CONI reads 0.
  - dr_split = rdi_data = 0.
- Bus reads are combinational from registers, valid in the same cycle as the select/strobe.
- CONO effects and the DATAI chg clear are visible the cycle after the strobe.
- The first tick comes SCAN_DIV cycles after en becomes 1. Each box is sampled every 4·SCAN_DIV cycles.
- Change latency: a level change held stable on box k updates snap and sets chg on its (DEB_N+1)-th sample. Worst case is (DEB_N+2)·4·SCAN_DIV cycles from input change to pi_req.
- Boundaries:
  - A glitch shorter than one sample interval is either never sampled or resets cnt; snap is unchanged.
  - A change back to snap's value before DEB_N completes produces no chg.
  - en cleared mid-debounce freezes cnt/prev/bi; scanning resumes where it left off.
  - reset mid-debounce discards all progress.

## Test plan
- Reset with no inputs (SCAN_DIV=4, DEB_N=2 for all tests) → DATAI 777777777777₈, CONI 0, pi_req 0.
- CONO set 25₈, then hold ctl1[12]=1 → CONI 000000000025₈. Within 4·16 cycles, chg=1, pi_req=7'b0000100, DATAI 777777777377₈.
- ctl2[14] high for 3 cycles only → no snap change, chg stays 0, DATAI unchanged.
- Hold DATAI selected while a stable ctl4[15] change completes → W unchanged and chg=0 while asserted. After release, the next box-4 tick updates snap: bit 3 of DATAI = 0 and chg=1.
- CONO set 10₈ with chg=1 → chg=0, pi_req=0. Then CONO clear → pia=0, en=0, and the timer stops (no ticks for 100 cycles).
- Assert iob_reset mid-debounce, then re-enable → the previous partial count is discarded, and a full DEB_N+1 samples are required before the update.
